// File: rtl/ov7670_pkg.sv
// ov7670_pkg: shared FSM states, pattern modes and bar colours for the OV7670 sensor emulator.
package ov7670_pkg;
    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;
    localparam logic [1:0] MODE_BARS  = 2'd0;
    localparam logic [1:0] MODE_RAMP  = 2'd1;
    localparam logic [1:0] MODE_CHECK = 2'd2;
    localparam logic [1:0] MODE_SOLID = 2'd3;
    // Entry 0 is the rightmost element: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [7:0][11:0] BAR_RGB = {12'h000, 12'h00F, 12'hF00, 12'hF0F,
                                            12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF};
endpackage

// File: rtl/ov7670_pattern_gen.sv
// ov7670_pattern_gen: combinational RGB444 test-pattern colour for pixel (x, y).
module ov7670_pattern_gen
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE = 640
) (
    input  logic [15:0] x_i,
    input  logic        y5_i,
    input  logic [1:0]  mode_i,
    input  logic [11:0] solid_rgb_i,
    input  logic        parity_i,
    output logic [11:0] rgb_o
);
    logic [2:0] bar;
    always_comb begin
        bar   = 3'(x_i / 16'(H_ACTIVE / 8));
        rgb_o = mode_i == MODE_BARS  ? BAR_RGB[bar] :
                mode_i == MODE_RAMP  ? {3{x_i[7:4]}} :
                mode_i == MODE_CHECK ? {12{x_i[5] ^ y5_i ^ parity_i}} : solid_rgb_i;
    end
endmodule

// File: rtl/ov7670_stream_tx.sv
// ov7670_stream_tx: OV7670-style VSYNC/HREF/D transmitter streaming RGB444 test frames.
module ov7670_stream_tx
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE      = 640,
    parameter int V_ACTIVE      = 480,
    parameter int H_BLANK       = 288,
    parameter int VSYNC_LINES   = 3,
    parameter int V_BACK_LINES  = 17,
    parameter int V_FRONT_LINES = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [11:0] solid_rgb,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  d,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  frame_cnt
);
    localparam int L    = 2 * H_ACTIVE + H_BLANK;
    localparam int M1   = VSYNC_LINES > V_BACK_LINES ? VSYNC_LINES : V_BACK_LINES;
    localparam int M2   = V_ACTIVE > V_FRONT_LINES ? V_ACTIVE : V_FRONT_LINES;
    localparam int MAXL = M1 > M2 ? M1 : M2;
    localparam int CW   = $clog2(L);
    localparam int LW   = $clog2(MAXL + 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  col_q, col_d;
    logic [LW-1:0]  line_q, line_d, n_lines;
    logic [1:0]     mode_q;
    logic [11:0]    solid_q, rgb;
    logic [15:0]    x;
    logic           y5, line_end, state_end, frame_end, start, act;
    logic           vsync_q, href_q, busy_q, done_q;
    logic [7:0]     d_q, d_d, cnt_q;

    always_comb begin
        line_end  = col_q == CW'(L - 1);
        n_lines   = state_q == VSYNC  ? LW'(VSYNC_LINES) :
                    state_q == VBACK  ? LW'(V_BACK_LINES) :
                    state_q == ACTIVE ? LW'(V_ACTIVE) : LW'(V_FRONT_LINES);
        state_end = line_end && line_q == n_lines - 1'b1;
        frame_end = state_q == VFRONT && state_end;
        start     = enable && (state_q == IDLE || frame_end);
        state_d   = state_q;
        case (state_q)
            IDLE:    state_d = enable ? VSYNC : IDLE;
            VSYNC:   if (state_end) state_d = VBACK;
            VBACK:   if (state_end) state_d = ACTIVE;
            ACTIVE:  if (state_end) state_d = VFRONT;
            default: if (state_end) state_d = enable ? VSYNC : IDLE;
        endcase
        col_d  = state_q == IDLE || line_end ? '0 : col_q + 1'b1;
        line_d = state_q == IDLE || state_end ? '0 : line_end ? line_q + 1'b1 : line_q;
        x      = 16'(col_q >> 1);
        y5     = |(16'(line_q) & 16'h0020);
        act    = state_q == ACTIVE && col_q < CW'(2 * H_ACTIVE);
        // Even byte carries R in the low nibble, odd byte carries {G,B}.
        d_d    = !act ? 8'h00 : col_q[0] ? rgb[7:0] : {4'h0, rgb[11:8]};
    end

    ov7670_pattern_gen #(.H_ACTIVE(H_ACTIVE)) u_pat (
        .x_i(x), .y5_i(y5), .mode_i(mode_q), .solid_rgb_i(solid_q),
        .parity_i(cnt_q[0]), .rgb_o(rgb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            line_q  <= '0;
            mode_q  <= MODE_BARS;
            solid_q <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            d_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            line_q  <= line_d;
            if (start) begin
                mode_q  <= mode;
                solid_q <= solid_rgb;
            end
            vsync_q <= state_q == VSYNC;
            href_q  <= act;
            d_q     <= d_d;
            busy_q  <= state_q != IDLE;
            done_q  <= frame_end;
            cnt_q   <= frame_end ? cnt_q + 8'd1 : cnt_q;
        end
    end

    assign vsync      = vsync_q;
    assign href       = href_q;
    assign d          = d_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign frame_cnt  = cnt_q;
endmodule

// File: tb/tb_ov7670_stream_tx.sv
// tb_ov7670_stream_tx: randomized frame-level checks of ov7670_stream_tx against a per-cycle reference.
module tb_ov7670_stream_tx;
    localparam int HA = 16, VA = 4, HB = 8, VS = 1, VB = 1, VF = 1;
    localparam int L  = 2 * HA + HB;
    localparam int FR = (VS + VB + VA + VF) * L;

    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [11:0] solid_rgb = 12'h000;
    logic        vsync, href, busy, frame_done;
    logic [7:0]  d, frame_cnt;
    int          n_checks = 0, n_fail = 0;
    logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

    ov7670_stream_tx #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
        .VSYNC_LINES(VS), .V_BACK_LINES(VB), .V_FRONT_LINES(VF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .solid_rgb(solid_rgb),
        .vsync(vsync), .href(href), .d(d), .busy(busy), .frame_done(frame_done),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] obs();
        return {frame_cnt, vsync, href, busy, frame_done, d};
    endfunction

    // Expected {frame_cnt,vsync,href,busy,frame_done,d} o cycles after the frame's start edge.
    function automatic logic [19:0] ref_vec(input int o, input int md, input logic [11:0] sol, input int cnt);
        int c, ln, col, x, y, fc;
        logic hr;
        logic [11:0] rgb;
        logic [7:0] dd;
        c   = o - 1;
        ln  = c / L;
        col = c % L;
        x   = col / 2;
        y   = ln - (VS + VB);
        hr  = ln >= VS + VB && ln < VS + VB + VA && col < 2 * HA;
        case (md)
            0:       rgb = bars[x / (HA / 8)];
            1:       rgb = {3{4'((x >> 4) & 15)}};
            2:       rgb = (((x >> 5) ^ (y >> 5) ^ cnt) & 1) != 0 ? 12'hFFF : 12'h000;
            default: rgb = sol;
        endcase
        dd = !hr ? 8'h00 : (col % 2 == 1) ? rgb[7:0] : {4'h0, rgb[11:8]};
        fc = o == FR ? cnt + 1 : cnt;
        return {8'(fc), ln < VS, hr, 1'b1, o == FR, dd};
    endfunction

    // Entered at the negedge right after the frame's start edge; leaves at the negedge after its last edge.
    task automatic frame_check(input int md, input logic [11:0] sol, input int cnt,
                               input int chg_at, input int new_md, input logic [11:0] new_sol,
                               input int drop_at);
        for (int o = 1; o <= FR; o++) begin
            @(negedge clk);
            check($sformatf("frame%0d_o%0d", cnt, o), 32'(obs()), 32'(ref_vec(o, md, sol, cnt)));
            if (o == chg_at) begin
                mode      = 2'(new_md);
                solid_rgb = new_sol;
            end
            if (o == drop_at) enable = 1'b0;
        end
    endtask

    initial begin
        int md_c, md_r;
        logic [11:0] sol_c, sol_r;
        bit seen;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 500; i++) begin
            @(negedge clk);
            if (i % 100 == 0) check("idle", 32'(obs()), 32'h0);
        end

        // Three frames: bars, then solid 5A3 set mid-frame, then a random pattern with enable dropped mid-frame.
        enable = 1'b1;
        mode   = 2'd0;
        @(negedge clk);
        md_c  = int'($urandom_range(0, 3));
        sol_c = 12'($urandom);
        frame_check(0, 12'h000, 0, 150, 3, 12'h5A3, 0);
        frame_check(3, 12'h5A3, 1, 100, md_c, sol_c, 0);
        frame_check(md_c, sol_c, 2, 0, 0, 12'h0, 150);
        @(negedge clk);
        check("after_drop", 32'(obs()), 32'h03000);

        for (int f = 0; f < 3; f++) begin
            md_r  = int'($urandom_range(0, 3));
            sol_r = 12'($urandom);
            mode      = 2'(md_r);
            solid_rgb = sol_r;
            enable    = 1'b1;
            @(negedge clk);
            frame_check(md_r, sol_r, 3 + f, 0, 0, 12'h0, 1 + int'($urandom_range(0, FR - 2)));
            @(negedge clk);
            check("rand_idle", 32'(obs()), 32'({8'(4 + f), 12'h000}));
        end

        // Asynchronous reset in the middle of an active line.
        mode   = 2'd0;
        enable = 1'b1;
        seen   = 1'b0;
        for (int i = 0; i < 2 * FR && !seen; i++) begin
            @(negedge clk);
            seen = href;
        end
        check("href_seen", 32'(seen), 32'h1);
        #2 rst_n = 1'b0;
        #1 check("async_rst", 32'(obs()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame_check(0, 12'h000, 0, 0, 0, 12'h0, 1);
        @(negedge clk);
        check("final_idle", 32'(obs()), 32'h01000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
